// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream boot loader that fills instruction memory and releases the core
module imem_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CHECK, DONE, ERROR} state_t;

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] last_word;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_word;
  logic [7:0]  csum;
  logic        accept;
  logic [15:0] len_n;

  assign in_ready = (state != DONE) && (state != ERROR);
  assign accept   = in_valid && in_ready;
  assign len_n    = {in_data, len_lo};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= LEN0;
      len_lo     <= 8'h00;
      last_word  <= 16'h0000;
      word_cnt   <= 16'h0000;
      byte_cnt   <= 2'd0;
      asm_word   <= 24'h000000;
      csum       <= 8'h00;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0000_0000;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          LEN0: begin
            len_lo <= in_data;
            state  <= LEN1;
          end
          LEN1: begin
            if ({1'b0, len_n} > DEPTH_LIM) begin
              state    <= ERROR;
              load_err <= 1'b1;
            end else if (len_n == 16'h0000) begin
              state <= CHECK;
            end else begin
              last_word <= len_n - 16'd1;
              state     <= DATA;
            end
          end
          DATA: begin
            // Shift bytes in from the top so the first byte lands in [7:0].
            csum     <= csum ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            asm_word <= {in_data, asm_word[23:8]};
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt[ADDR_W-1:0];
              imem_wdata <= {in_data, asm_word};
              word_cnt   <= word_cnt + 16'd1;
              if (word_cnt == last_word) state <= CHECK;
            end
          end
          CHECK: begin
            if (in_data == csum) begin
              state      <= DONE;
              load_done  <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state    <= ERROR;
              load_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader against a stream-level reference model
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_data = 8'h00;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              load_done;
  logic              load_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]        stream[$];
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];
  logic              prev_we = 1'b0;

  imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .load_done(load_done), .load_err(load_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: records every strobe and checks it never lasts two cycles.
  always @(negedge CLK) begin
    if (imem_we) begin
      chk("we_single_cycle", {63'd0, prev_we}, 64'd0);
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
    prev_we = imem_we;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge CLK);
  endtask

  task automatic idle_gaps(input int gap_pct);
    int n;
    n = 0;
    while (n < 5 && $urandom_range(99) < gap_pct) begin
      @(negedge CLK);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      n++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_we"}, {63'd0, imem_we}, 64'd0);
    chk({tag, "_addr"}, {58'd0, imem_addr}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, imem_wdata}, 64'd0);
    chk({tag, "_core_rst_n"}, {63'd0, core_rst_n}, 64'd0);
    chk({tag, "_done"}, {63'd0, load_done}, 64'd0);
    chk({tag, "_err"}, {63'd0, load_err}, 64'd0);
    chk({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    in_valid = 1'b0;
    #2 RST = 1'b0;
    #1 check_reset_state("reset");
    @(negedge CLK);
    RST = 1'b1;
    got_addr.delete();
    got_data.delete();
  endtask

  // Sends the global stream with random idle gaps and compares against the model.
  task automatic run_stream(input string tag, input int gap_pct);
    int unsigned n;
    logic [7:0]  x;
    logic        exp_done, exp_err;
    int          exp_sent, sent;
    logic [31:0] exp_w[$];

    n = {stream[1], stream[0]};
    x = 8'h00;
    exp_w.delete();
    if (n > DEPTH) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      exp_sent = 2;
    end else begin
      for (int k = 0; k < int'(n); k++)
        exp_w.push_back({stream[2+4*k+3], stream[2+4*k+2], stream[2+4*k+1], stream[2+4*k]});
      for (int i = 2; i < 2 + 4 * int'(n); i++) x = x ^ stream[i];
      exp_done = (stream[2+4*n] == x);
      exp_err  = !exp_done;
      exp_sent = 3 + 4 * int'(n);
    end

    got_addr.delete();
    got_data.delete();
    sent = 0;
    foreach (stream[i]) begin
      idle_gaps(gap_pct);
      @(negedge CLK);
      if (!in_ready) break;
      chk({tag, "_core_held"}, {63'd0, core_rst_n}, 64'd0);
      in_valid = 1'b1;
      in_data  = stream[i];
      @(posedge CLK);
      sent++;
    end
    #1;
    chk({tag, "_core_rst_n_at_end"}, {63'd0, core_rst_n}, {63'd0, exp_done});
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
    end
    @(negedge CLK);
    in_valid = 1'b0;

    chk({tag, "_accepted"}, 64'(sent), 64'(exp_sent));
    chk({tag, "_done"}, {63'd0, load_done}, {63'd0, exp_done});
    chk({tag, "_err"}, {63'd0, load_err}, {63'd0, exp_err});
    chk({tag, "_core_rst_n"}, {63'd0, core_rst_n}, {63'd0, exp_done});
    chk({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
    chk({tag, "_we_idle"}, {63'd0, imem_we}, 64'd0);
    chk({tag, "_nwrites"}, 64'(got_data.size()), 64'(exp_w.size()));
    for (int k = 0; k < exp_w.size() && k < got_data.size(); k++) begin
      chk({tag, "_addr"}, {58'd0, got_addr[k]}, 64'(k));
      chk({tag, "_wdata"}, {32'd0, got_data[k]}, {32'd0, exp_w[k]});
    end
  endtask

  initial begin
    logic [7:0] x;
    int         n;

    #3;
    check_reset_state("initial_reset");
    @(negedge CLK);
    RST = 1'b1;

    stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    run_stream("one_word", 0);

    do_reset();
    stream = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    run_stream("two_words", 0);

    do_reset();
    stream = '{8'h00, 8'h00, 8'h00};
    run_stream("zero_len_ok", 0);

    do_reset();
    stream = '{8'h00, 8'h00, 8'h01};
    run_stream("zero_len_bad", 0);

    do_reset();
    stream = '{8'h41, 8'h00, 8'h12, 8'h34, 8'h56};
    run_stream("len_too_big", 0);

    do_reset();
    stream = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    run_stream("two_words_gaps", 50);

    // Abandon a partial image mid-word, then a clean load must restart at address 0.
    do_reset();
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i));
    @(negedge CLK);
    in_valid = 1'b0;
    do_reset();
    stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    run_stream("after_abort", 0);

    // Largest legal image exercises the top address.
    do_reset();
    stream = '{8'(DEPTH), 8'h00};
    x = 8'h00;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      stream.push_back(8'($urandom));
      x = x ^ stream[stream.size()-1];
    end
    stream.push_back(x);
    run_stream("full_depth", 10);

    for (int t = 0; t < 8; t++) begin
      do_reset();
      n = $urandom_range(0, 6);
      stream = '{8'(n), 8'h00};
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        stream.push_back(8'($urandom));
        x = x ^ stream[stream.size()-1];
      end
      if ($urandom_range(3) == 0) x = x ^ 8'(1 << $urandom_range(7));
      stream.push_back(x);
      run_stream("random", int'($urandom_range(0, 60)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
